// File: rtl/arrmult_pkg.sv
// ---------------------------------------------------------------------------
// Package: arrmult_pkg
// Purpose: Shared definitions for the multiply-accumulate datapath that sits
//          behind the 4x8 array multiplier.
// Contents:
//   PW_DEFAULT   default product width (the 4x8 multiplier output is 12 bits)
//   acc_state_t  two-state accumulator FSM encoding (ACC, HOLD)
//   clog2        elaboration-time ceil(log2(value)) helper for sizing counters
// ---------------------------------------------------------------------------
package arrmult_pkg;

   localparam int PW_DEFAULT = 12;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_t;

   // Ceiling log2 used to size counters. Values of 0 or 1 give 0, so
   // callers size a counter for N states by passing N.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/acc_sat_add.sv
// ---------------------------------------------------------------------------
// Module: acc_sat_add
// Purpose: Unsigned ACC_W-bit adder for the product accumulator. Reports the
//          carry out of the add so the caller can record overflow.
// Configuration macro: ACCUM_SAT_EN
//   defined   -> on a carry the sum clamps to 2^ACC_W-1
//   undefined -> the sum wraps modulo 2^ACC_W
// Ports:
//   a      in   ACC_W  running accumulator value
//   b      in   ACC_W  zero-extended product to add
//   sum    out  ACC_W  result (wrapped or saturated)
//   carry  out  1      carry out of the full-width add
// ---------------------------------------------------------------------------
module acc_sat_add #(
   parameter int ACC_W = 20
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw_sum;

   // Add with one extra bit so the carry is visible. In saturating builds a
   // carry clamps to all ones; an already-saturated accumulator then carries
   // again on any non-zero product and therefore stays clamped.
   always_comb begin
      raw_sum = {1'b0, a} + {1'b0, b};
      carry   = raw_sum[ACC_W];
`ifdef ACCUM_SAT_EN
      sum     = carry ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
      sum     = raw_sum[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/prod_accumulator.sv
// ---------------------------------------------------------------------------
// Module: prod_accumulator
// Purpose: Accumulate half of the multiply-accumulate datapath. Takes the
//          unsigned product stream from the 4x8 array multiplier over a
//          valid/ready handshake, sums N_TERMS products (fewer when in_last
//          closes the sum early) and presents the sum, the term count and an
//          overflow flag over an output valid/ready handshake.
// Configuration macro: ACCUM_SAT_EN (selects saturating add in acc_sat_add)
// Parameters:
//   PW       product width
//   ACC_W    accumulator / out_sum width (>= PW)
//   N_TERMS  products per sum (>= 1)
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      in_prod/in_last are valid
//   in_ready   out  1      a product can be accepted this cycle
//   in_prod    in   PW     unsigned product
//   in_last    in   1      this product closes the current sum
//   out_valid  out  1      out_sum/out_count/out_ovf are valid
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  ACC_W  accumulated sum
//   out_count  out  CW     number of products in out_sum
//   out_ovf    out  1      the sum overflowed ACC_W bits at some point
// ---------------------------------------------------------------------------
module prod_accumulator
   import arrmult_pkg::*;
#(
   parameter int PW      = PW_DEFAULT,
   parameter int ACC_W   = 20,
   parameter int N_TERMS = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [PW-1:0]                    in_prod,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_W-1:0]                 out_sum,
   output logic [clog2(N_TERMS+1)-1:0]      out_count,
   output logic                             out_ovf
);

   localparam int CW = clog2(N_TERMS + 1);

   acc_state_t      state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [CW-1:0]    cnt_inc;

   assign prod_ext = ACC_W'(in_prod);
   assign cnt_inc  = cnt_q + CW'(1);

   acc_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a     (acc_q),
      .b     (prod_ext),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // Next-state logic. In ACC every accepted product is added and counted;
   // the sum closes when the count reaches N_TERMS or in_last is seen.
   // In HOLD nothing is accepted, so a product offered in the same cycle as
   // out_ready simply waits one cycle and becomes the first term of the next
   // sum.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACC: begin
            if (in_valid) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_carry;
               if ((cnt_inc == CW'(N_TERMS)) || in_last) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACC;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   // State and datapath registers. Reset discards any partial sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake outputs depend only on the state register, and the result
   // outputs come straight from the registers, so there are no combinational
   // paths from any input to any output.
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench: tb_prod_accumulator
// Purpose: Directed self-checking bench for prod_accumulator. A default
//          instance (ACC_W=20, N_TERMS=16) covers the handshake, HOLD
//          behaviour, reset and a golden-sum stream; a narrow instance
//          (ACC_W=14) covers overflow, with the expected value chosen by
//          ACCUM_SAT_EN.
// ---------------------------------------------------------------------------
module tb_prod_accumulator;
   import arrmult_pkg::*;

   localparam int PW       = 12;
   localparam int ACC_W    = 20;
   localparam int NARROW_W = 14;
   localparam int N_TERMS  = 16;
   localparam int CW       = clog2(N_TERMS + 1);

   logic clk;
   logic rst;

   logic                in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [PW-1:0]       in_prod;
   logic [ACC_W-1:0]    out_sum;
   logic [CW-1:0]       out_count;

   logic                w_in_valid, w_in_ready, w_in_last, w_out_valid, w_out_ready, w_out_ovf;
   logic [PW-1:0]       w_in_prod;
   logic [NARROW_W-1:0] w_out_sum;
   logic [CW-1:0]       w_out_count;

   int checkCount  = 0;
   int errorCount  = 0;

   prod_accumulator #(
      .PW(PW), .ACC_W(ACC_W), .N_TERMS(N_TERMS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
   );

   prod_accumulator #(
      .PW(PW), .ACC_W(NARROW_W), .N_TERMS(N_TERMS)
   ) dutNarrow (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_prod(w_in_prod), .in_last(w_in_last),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_sum(w_out_sum), .out_count(w_out_count), .out_ovf(w_out_ovf)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven and
   // outputs sampled here, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one product after an idle gap and hold it until accepted.
   task automatic applyStimulus(input logic [PW-1:0] prod, input logic last, input int gap);
      int waited;
      waited   = 0;
      in_valid = 1'b0;
      repeat (gap) step();
      in_valid = 1'b1;
      in_prod  = prod;
      in_last  = last;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      int nTerms;
      int golden;
      int a;
      int b;
      logic lastFlag;

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_prod     = '0;
      in_last     = 1'b0;
      out_ready   = 1'b0;
      w_in_valid  = 1'b0;
      w_in_prod   = '0;
      w_in_last   = 1'b0;
      w_out_ready = 1'b1;
      repeat (2) step();

      checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_sum",   32'(out_sum),   32'd0);
      checkOutput("reset_out_count", 32'(out_count), 32'd0);
      checkOutput("reset_out_ovf",   32'(out_ovf),   32'd0);
      rst = 1'b0;
      step();

      // 1: sixteen products of 1 close the sum at the term limit.
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(12'd1, 1'b0, 0);
      checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_out_sum",   32'(out_sum),   32'd16);
      checkOutput("t1_out_count", 32'(out_count), 32'd16);
      checkOutput("t1_out_ovf",   32'(out_ovf),   32'd0);
      step();
      checkOutput("t1_valid_one_cycle", 32'(out_valid), 32'd0);
      checkOutput("t1_sum_cleared",     32'(out_sum),   32'd0);

      // 2: early close with in_last.
      out_ready = 1'b0;
      applyStimulus(12'd3825, 1'b0, 0);
      applyStimulus(12'd3825, 1'b0, 0);
      applyStimulus(12'd100,  1'b1, 0);
      checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_out_sum",   32'(out_sum),   32'd7750);
      checkOutput("t2_out_count", 32'(out_count), 32'd3);
      checkOutput("t2_in_ready",  32'(in_ready),  32'd0);

      // 3: stall in HOLD with a product waiting.
      in_valid = 1'b1;
      in_prod  = 12'd7;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("t3_hold_sum",   32'(out_sum),   32'd7750);
         checkOutput("t3_hold_count", 32'(out_count), 32'd3);
         checkOutput("t3_hold_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      step();
      checkOutput("t3_release_valid", 32'(out_valid), 32'd0);
      checkOutput("t3_not_taken_sum", 32'(out_sum),   32'd0);
      checkOutput("t3_not_taken_cnt", 32'(out_count), 32'd0);
      step();
      in_valid = 1'b0;
      checkOutput("t3_taken_sum", 32'(out_sum),   32'd7);
      checkOutput("t3_taken_cnt", 32'(out_count), 32'd1);
      out_ready = 1'b0;
      applyStimulus(12'd5, 1'b1, 0);
      checkOutput("t3_next_sum",   32'(out_sum),   32'd12);
      checkOutput("t3_next_count", 32'(out_count), 32'd2);
      out_ready = 1'b1;
      step();

      // 4: overflow on the 14-bit instance.
      w_in_valid = 1'b1;
      w_in_prod  = 12'd3825;
      for (int i = 0; i < 5; i++) begin
         w_in_last = (i == 4);
         step();
      end
      w_in_valid = 1'b0;
      w_in_last  = 1'b0;
      checkOutput("t4_out_valid", 32'(w_out_valid), 32'd1);
`ifdef ACCUM_SAT_EN
      checkOutput("t4_out_sum",   32'(w_out_sum),   32'd16383);
`else
      checkOutput("t4_out_sum",   32'(w_out_sum),   32'd2741);
`endif
      checkOutput("t4_out_count", 32'(w_out_count), 32'd5);
      checkOutput("t4_out_ovf",   32'(w_out_ovf),   32'd1);
      step();
      checkOutput("t4_ovf_cleared", 32'(w_out_ovf), 32'd0);

      // 5: reset in the middle of a sum.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(12'd10, 1'b0, 0);
      checkOutput("t5_partial_sum", 32'(out_sum), 32'd40);
      rst = 1'b1;
      #1;
      checkOutput("t5_reset_sum",   32'(out_sum),   32'd0);
      checkOutput("t5_reset_count", 32'(out_count), 32'd0);
      checkOutput("t5_reset_ready", 32'(in_ready),  32'd1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(12'd5, 1'b0, 0);
      checkOutput("t5_full_sum",   32'(out_sum),   32'd80);
      checkOutput("t5_full_count", 32'(out_count), 32'd16);
      step();

      // 6: golden-sum stream with random gaps and back-pressure.
      out_ready = 1'b0;
      for (int s = 0; s < 6; s++) begin
         nTerms = (s == 0) ? 16 : $urandom_range(1, 16);
         golden = 0;
         for (int t = 0; t < nTerms; t++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 255);
            golden = golden + a * b;
            lastFlag = (t == nTerms - 1) && ((nTerms != 16) || ($urandom_range(0, 1) == 1));
            applyStimulus(12'(a * b), lastFlag, $urandom_range(0, 2));
         end
         checkOutput("t6_out_valid", 32'(out_valid), 32'd1);
         checkOutput("t6_out_sum",   32'(out_sum),   32'(golden));
         checkOutput("t6_out_count", 32'(out_count), 32'(nTerms));
         repeat ($urandom_range(0, 3)) step();
         checkOutput("t6_held_sum", 32'(out_sum), 32'(golden));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
